mcif_read_ig_wrr_arb: RTL and testbench

Weighted round-robin arbiter for the MCIF read ingress path. It merges the per-client read-request streams (each already passed through its own valid/ready skid pipe) into one request stream toward the read splitter. It grants each client a burst of up to weight+1 back-to-back requests, then rotates. The result is registered through a single output stage and tagged with the winning client id.

---
 rtl/mcif_read_ig_pkg.sv | 41 ++++
 rtl/mcif_rr_pick.sv | 27 ++
 rtl/mcif_read_ig_wrr_arb.sv | 110 +++++++++++
 tb/tb_mcif_read_ig_wrr_arb.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_read_ig_pkg.sv
// Shared defaults and the rotating-priority search used by the MCIF read ingress arbiter.
package mcif_read_ig_pkg;

  localparam int unsigned NUM_SRC = 10;
  localparam int unsigned PD_W    = 75;
  localparam int unsigned WT_W    = 8;
  localparam int unsigned ID_W    = 4;

  // Search width is fixed; callers zero-extend their request vector.
  localparam int unsigned MAX_SRC = 32;
  localparam int unsigned IDX_W   = 5;

  typedef struct packed {
    logic [MAX_SRC-1:0] oh;
    logic [IDX_W-1:0]   idx;
  } rr_pick_t;

  // First set bit of req[n-1:0] scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_first(input logic [MAX_SRC-1:0] req,
                                        input int unsigned n,
                                        input int unsigned ptr);
    rr_pick_t    r;
    int unsigned i;
    logic        found;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      if (k < n && !found) begin
        i = ptr + k;
        if (i >= n) i = i - n;
        if (req[i[IDX_W-1:0]]) begin
          found                = 1'b1;
          r.oh[i[IDX_W-1:0]]   = 1'b1;
          r.idx                = i[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mcif_rr_pick.sv
// Combinational rotating-priority picker: grants the first requester at or after ptr.
module mcif_rr_pick
  import mcif_read_ig_pkg::*;
#(
  parameter int unsigned N    = mcif_read_ig_pkg::NUM_SRC,
  parameter int unsigned ID_W = mcif_read_ig_pkg::ID_W
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_oh,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic [MAX_SRC-1:0] req_ext;
  rr_pick_t           p;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    p                = rr_first(req_ext, N, 32'(ptr));
    gnt_oh           = p.oh[N-1:0];
    gnt_idx          = ID_W'(p.idx);
    any              = |p.oh;
  end

endmodule

// File: rtl/mcif_read_ig_wrr_arb.sv
// Weighted round-robin merge of per-client read requests into one registered, id-tagged stream.
module mcif_read_ig_wrr_arb
  import mcif_read_ig_pkg::*;
#(
  parameter int unsigned NUM_SRC = mcif_read_ig_pkg::NUM_SRC,
  parameter int unsigned PD_W    = mcif_read_ig_pkg::PD_W,
  parameter int unsigned WT_W    = mcif_read_ig_pkg::WT_W,
  parameter int unsigned ID_W    = mcif_read_ig_pkg::ID_W
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic [NUM_SRC-1:0]      src_vld,
  output logic [NUM_SRC-1:0]      src_rdy,
  input  logic [NUM_SRC*PD_W-1:0] src_pd,
  input  logic [NUM_SRC*WT_W-1:0] reg2arb_wt,
  output logic                    arb_out_vld,
  input  logic                    arb_out_rdy,
  output logic [PD_W-1:0]         arb_out_pd,
  output logic [ID_W-1:0]         arb_out_id
);

  logic [PD_W-1:0] pd_arr [NUM_SRC];
  logic [WT_W-1:0] wt_arr [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pd_arr[i] = src_pd[i*PD_W +: PD_W];
      wt_arr[i] = reg2arb_wt[i*WT_W +: WT_W];
    end
  end

  logic [ID_W-1:0]    ptr_q, ptr_d, cur_q, cur_d, sel_idx;
  logic               burst_act_q, burst_act_d;
  logic [WT_W-1:0]    burst_rem_q, burst_rem_d;
  logic               out_vld_q;
  logic [PD_W-1:0]    out_pd_q;
  logic [ID_W-1:0]    out_id_q;
  logic [NUM_SRC-1:0] gnt_oh;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any, can_acc, cont, xfer;

  mcif_rr_pick #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_pick (
    .req     (src_vld),
    .ptr     (ptr_q),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign can_acc = !out_vld_q || arb_out_rdy;
  assign cont    = can_acc && burst_act_q && src_vld[cur_q] && (burst_rem_q != '0);

  always_comb begin
    src_rdy     = '0;
    sel_idx     = cur_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    burst_act_d = burst_act_q;
    burst_rem_d = burst_rem_q;
    if (can_acc && !nvdla_core_rst) begin
      if (cont) begin
        src_rdy[cur_q] = 1'b1;
        burst_rem_d    = burst_rem_q - 1'b1;
      end else if (gnt_any) begin
        // Covers a fresh grant and an owner dropping valid mid-burst alike.
        src_rdy     = gnt_oh;
        sel_idx     = gnt_idx;
        cur_d       = gnt_idx;
        burst_act_d = 1'b1;
        burst_rem_d = wt_arr[gnt_idx];
        ptr_d       = (gnt_idx == ID_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        burst_act_d = 1'b0;
      end
    end
    xfer = |src_rdy;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      ptr_q       <= '0;
      cur_q       <= '0;
      burst_act_q <= 1'b0;
      burst_rem_q <= '0;
      out_vld_q   <= 1'b0;
      out_pd_q    <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      burst_act_q <= burst_act_d;
      burst_rem_q <= burst_rem_d;
      if (xfer) begin
        out_vld_q <= 1'b1;
        out_pd_q  <= pd_arr[sel_idx];
        out_id_q  <= sel_idx;
      end else if (can_acc) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign arb_out_vld = out_vld_q;
  assign arb_out_pd  = out_pd_q;
  assign arb_out_id  = out_id_q;

endmodule

// File: tb/tb_mcif_read_ig_wrr_arb.sv
// Bench for the weighted round-robin read ingress arbiter: directed scenarios plus random traffic.
module tb_mcif_read_ig_wrr_arb;

  localparam int N    = 10;
  localparam int PD_W = 75;
  localparam int WT_W = 8;
  localparam int ID_W = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         src_vld;
  logic [N-1:0]         src_rdy;
  logic [N*PD_W-1:0]    src_pd;
  logic [N*WT_W-1:0]    src_wt;
  logic                 arb_out_vld;
  logic                 arb_out_rdy;
  logic [PD_W-1:0]      arb_out_pd;
  logic [ID_W-1:0]      arb_out_id;

  mcif_read_ig_wrr_arb #(
    .NUM_SRC (N),
    .PD_W    (PD_W),
    .WT_W    (WT_W),
    .ID_W    (ID_W)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .src_vld        (src_vld),
    .src_rdy        (src_rdy),
    .src_pd         (src_pd),
    .reg2arb_wt     (src_wt),
    .arb_out_vld    (arb_out_vld),
    .arb_out_rdy    (arb_out_rdy),
    .arb_out_pd     (arb_out_pd),
    .arb_out_id     (arb_out_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int              cap_id [$];
  logic [PD_W-1:0] cap_pd [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the grant this cycle, how many beats it has
  // taken, and the beat budget (weight+1) fixed when the grant was won.
  int              m_ptr = 0, m_cur = 0, m_beats = 0, m_lim = 0;
  bit              m_act = 1'b0;
  logic            m_vld = 1'b0;
  logic [PD_W-1:0] m_pd  = '0;
  int              m_id  = 0;

  function automatic int pick(output bit cont);
    cont = 1'b0;
    if (rst) return -1;
    if (m_vld && !arb_out_rdy) return -1;
    if (m_act && src_vld[m_cur] && m_beats < m_lim) begin
      cont = 1'b1;
      return m_cur;
    end
    for (int k = 0; k < N; k++) begin
      if (src_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_upd
    int w;
    bit c;
    w = pick(c);
    if (rst) begin
      m_ptr = 0; m_cur = 0; m_beats = 0; m_lim = 0; m_act = 0;
      m_vld = 0; m_pd = '0; m_id = 0;
    end else if (!m_vld || arb_out_rdy) begin
      if (w >= 0) begin
        if (!c) begin
          m_cur   = w;
          m_act   = 1'b1;
          m_beats = 0;
          m_lim   = int'(src_wt[w*WT_W +: WT_W]) + 1;
          m_ptr   = (w + 1) % N;
        end
        m_beats++;
        m_vld = 1'b1;
        m_pd  = src_pd[w*PD_W +: PD_W];
        m_id  = w;
      end else begin
        m_act = 1'b0;
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int           w;
    bit           c;
    logic [N-1:0] e;
    if (chk_en) begin
      w = pick(c);
      e = '0;
      if (w >= 0) e[w] = 1'b1;
      chk("src_rdy", 128'(src_rdy), 128'(e));
      chk("out_vld", 128'(arb_out_vld), 128'(m_vld));
      chk("out_id", 128'(arb_out_id), 128'(m_id));
      chk("out_pd", 128'(arb_out_pd), 128'(m_pd));
      if (arb_out_vld && arb_out_rdy) begin
        cap_id.push_back(int'(arb_out_id));
        cap_pd.push_back(arb_out_pd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst     = 1'b1;
    src_vld = v;
    #1;
    chk("rst_rdy", 128'(src_rdy), 128'(0));
    cyc();
    rst = 1'b0;
    chk("rst_out_vld", 128'(arb_out_vld), 128'(0));
    chk("rst_out_id", 128'(arb_out_id), 128'(0));
    chk("rst_out_pd", 128'(arb_out_pd), 128'(0));
    cap_id.delete();
    cap_pd.delete();
  endtask

  task automatic chk_seq(input string name, input int exp [$]);
    chk({name, "_len"}, 128'(cap_id.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      chk(name, 128'((i < cap_id.size()) ? cap_id[i] : -1), 128'(exp[i]));
    end
  endtask

  task automatic set_wt(input int idx, input int w);
    src_wt[idx*WT_W +: WT_W] = WT_W'(w);
  endtask

  initial begin
    rst         = 1'b1;
    src_vld     = '0;
    src_pd      = '0;
    src_wt      = '0;
    arb_out_rdy = 1'b1;
    do_reset('0);
    chk_en = 1'b1;

    // Single client, weight 0: five back-to-back outputs tagged 3.
    src_vld = N'(1) << 3;
    run(5);
    src_vld = '0;
    run(2);
    chk_seq("single", '{3, 3, 3, 3, 3});

    // Weighted rotation: client 0 gets three beats, client 1 one.
    do_reset('0);
    set_wt(0, 2);
    set_wt(1, 0);
    src_vld = N'(3);
    run(8);
    src_vld = '0;
    run(2);
    chk_seq("weighted", '{0, 0, 0, 1, 0, 0, 0, 1});

    // Wrap and skip: after 8 wins, the pointer sits at 9 and wraps to 0.
    do_reset('0);
    src_wt  = '0;
    src_vld = N'(1) << 8;
    cyc();
    src_vld = (N'(1) << 9) | (N'(1) << 2);
    run(5);
    src_vld = '0;
    run(2);
    chk_seq("wrap", '{8, 9, 2, 9, 2, 9});

    // Owner 4 (weight 5) drops after two beats; 6 takes the same cycle.
    do_reset('0);
    set_wt(4, 5);
    src_vld = (N'(1) << 4) | (N'(1) << 6);
    run(2);
    src_vld = N'(1) << 6;
    cyc();
    src_vld = (N'(1) << 4) | (N'(1) << 6);
    run(7);
    src_vld = '0;
    run(2);
    chk_seq("drop", '{4, 4, 6, 4, 4, 4, 4, 4, 4, 6});

    // Backpressure with an output held for four cycles.
    do_reset('0);
    src_wt = '0;
    set_wt(0, 3);
    src_vld = N'(1);
    src_pd[0 +: PD_W] = PD_W'(75'h1111);
    cyc();
    src_pd[0 +: PD_W] = PD_W'(75'h2222);
    cyc();
    arb_out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      src_pd[0 +: PD_W] = PD_W'($urandom);
      #1;
      chk("stall_rdy", 128'(src_rdy), 128'(0));
      chk("stall_vld", 128'(arb_out_vld), 128'(1));
      chk("stall_pd", 128'(arb_out_pd), 128'(75'h2222));
      chk("stall_id", 128'(arb_out_id), 128'(0));
      cyc();
    end
    arb_out_rdy = 1'b1;
    src_pd[0 +: PD_W] = PD_W'(75'h3333);
    cyc();
    src_vld = '0;
    run(2);
    chk("bp_len", 128'(cap_pd.size()), 128'(3));
    chk("bp_pd0", 128'((cap_pd.size() > 0) ? cap_pd[0] : '1), 128'(75'h1111));
    chk("bp_pd1", 128'((cap_pd.size() > 1) ? cap_pd[1] : '1), 128'(75'h2222));
    chk("bp_pd2", 128'((cap_pd.size() > 2) ? cap_pd[2] : '1), 128'(75'h3333));

    // Reset mid-burst of client 5; next grant goes to lowest valid index.
    do_reset('0);
    src_wt = '0;
    set_wt(5, 4);
    src_vld = N'(1) << 5;
    run(2);
    do_reset((N'(1) << 2) | (N'(1) << 5));
    cyc();
    src_vld = '0;
    run(2);
    chk("rst_first", 128'((cap_id.size() > 0) ? cap_id[0] : -1), 128'(2));

    // Random traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) src_vld = N'($urandom);
      else src_vld = N'($urandom) & N'($urandom);
      arb_out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        src_pd[i*PD_W +: PD_W] = PD_W'({$urandom, $urandom, $urandom});
      end
      if (t % 50 == 0) begin
        for (int i = 0; i < N; i++) begin
          set_wt(i, ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3)));
        end
      end
      cyc();
    end
    rst = 1'b0;
    src_vld = '0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
